grid_link_rx: RTL and testbench
===============================

Name: grid_link_rx

Overview:
- Far-end receiver for one 4-bit grid serial link (the txd[3:0] lanes produced by the grid receiver's per-channel router transmitters).
- Hunts for a start-of-frame (SOF) nibble, then deserializes 32 data nibbles into a 128-bit packet and verifies a check nibble.
- Presents each good packet on a valid/ready interface toward the local router/FIFO.
- Drives cts back to the transmitter for flow control.
- One instance per channel, all in the clk57 domain.

Parameters:
- SOF, 4'hA, start-of-frame nibble.
- NNYB, 32, data nibbles per packet; packet width is 4*NNYB = 128.
- CNT_W, 16, width of the error and overflow counters.

Ports:
- clk57  in  1  link/system clock; same clock as the transmitter's sclk.
- rst  in  1  reset, synchronous, active-high.
- rxd  in  4  serial nibble lane; idle value is 4'h0.
- dat_o  out  128  received packet; first nibble received lands in [127:124].
- vld_o  out  1  dat_o holds a valid packet.
- rdy_i  in  1  consumer accepts dat_o when vld_o && rdy_i.
- cts_o  out  1  clear-to-send to the transmitter.
- busy_o  out  1  frame in progress (state != HUNT).
- err_cnt_o  out  CNT_W  count of check-nibble failures; saturating.
- ovf_cnt_o  out  CNT_W  count of good packets dropped because the output register was full; saturating.

Behaviour:
- Reset values: vld_o=0, dat_o=0, cts_o=1, busy_o=0, both counters 0, state=HUNT, internal rxd_q=0.
- Input stage: rxd is registered into rxd_q every cycle; the FSM acts only on rxd_q.
- HUNT:
  - rxd_q==SOF: clear the shift register and the check accumulator, nibble count=0, go to DATA.
  - Any other value: stay in HUNT.
- DATA, each cycle:
  - Shift: shreg = {shreg[123:0], rxd_q}; chk ^= rxd_q; count++.
  - After the 32nd nibble (count==NNYB-1), go to CHECK.
  - No nibble value is special inside DATA; SOF and 0 are treated as ordinary data.
- CHECK: compare rxd_q against chk. In every outcome the next state is HUNT.
  - Mismatch: increment err_cnt_o (saturating), discard the packet.
  - Match with shreg[127:120]==8'h00: null packet, discarded silently, no counter change.
  - Match with non-null packet, and (!vld_o || rdy_i): dat_o<=shreg, vld_o<=1.
  - Match with non-null packet, and vld_o && !rdy_i: drop the packet, increment ovf_cnt_o (saturating), dat_o unchanged.
- Output handshake:
  - vld_o falls the cycle after vld_o && rdy_i, unless CHECK reloads the register in the same cycle; then vld_o stays 1 with the new data.
  - dat_o is stable while vld_o && !rdy_i.
- Latency: check nibble on rxd at edge k, then vld_o high after edge k+2. Minimum frame is 34 nibbles (SOF + 32 data + check). Back-to-back frames need no idle nibble between them.
- cts_o is registered: cts_o <= !(vld_o && !rdy_i). The transmitter only samples cts before starting a frame; a frame already in flight is always received in full.
- Counters saturate at all ones; they are cleared only by rst.
- rst mid-frame: the partial frame is abandoned and no counters change.
- busy_o = (state==DATA || state==CHECK).

Decomposition:
- Shared package grid_link_pkg holds:
  - constants GRID_SOF=4'hA, GRID_IDLE=4'h0, GRID_NNYB=32, GRID_PKT_W=128;
  - state encoding HUNT=2'd0, DATA=2'd1, CHECK=2'd2.
- The matching transmitter reuses the same package.
- One natural sub-module, grid_nyb_deser: the shift register, nibble counter and XOR check accumulator, with ports clr, shift, nyb_in, pkt, chk, last.
- The top level keeps the FSM, the output register, cts and the counters.

Test Plan:
- Single good frame: SOF, nibbles 0x1..0xF then 0x0 repeated to fill 32 (first byte 0x12), correct XOR check nibble, rdy_i=1 -> vld_o pulses for 1 cycle, 2 clocks after the check nibble; dat_o[127:120]=8'h12; err_cnt_o and ovf_cnt_o stay 0.
- Bad check: same frame with the check nibble XOR 4'h1 -> vld_o stays 0, err_cnt_o=1, FSM returns to HUNT and a following good frame is received.
- Null packet: first two data nibbles 0, valid check -> no vld_o, all counters stay 0.
- Backpressure: rdy_i=0, two good frames back-to-back -> first frame held on dat_o; cts_o=0 one cycle after vld_o rises; second frame dropped; ovf_cnt_o=1; after rdy_i=1, vld_o falls the next cycle and cts_o returns to 1.
- Simultaneous accept/reload: rdy_i rises in the exact CHECK cycle of frame 2 -> vld_o stays 1, dat_o=frame 2, ovf_cnt_o=0.
- Reset mid-frame: assert rst after 10 data nibbles -> busy_o=0, vld_o=0, cts_o=1; the remaining nibbles (none equal to SOF) are ignored; the next SOF frame is received correctly.

Source files
------------

// File: rtl/grid_link_pkg.sv
// rtl/grid_link_pkg.sv - shared constants and FSM encoding for the 4-bit grid serial link
package grid_link_pkg;

    localparam logic [3:0] GRID_SOF   = 4'hA;
    localparam logic [3:0] GRID_IDLE  = 4'h0;
    localparam int         GRID_NNYB  = 32;
    localparam int         GRID_PKT_W = 4 * GRID_NNYB;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        DATA  = 2'd1,
        CHECK = 2'd2
    } grid_state_t;

endpackage

// File: rtl/grid_nyb_deser.sv
// rtl/grid_nyb_deser.sv - nibble shift register, nibble counter and XOR check accumulator
module grid_nyb_deser
    import grid_link_pkg::*;
#(
    parameter int NNYB = GRID_NNYB
) (
    input  logic                clk57,
    input  logic                rst,
    input  logic                clr,
    input  logic                shift,
    input  logic [3:0]          nyb_in,
    output logic [4*NNYB-1:0]   pkt,
    output logic [3:0]          chk,
    output logic                last
);

    localparam int              CW       = $clog2(NNYB);
    localparam logic [CW-1:0]   LAST_IDX = CW'(NNYB - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk57) begin
        if (rst || clr) begin
            pkt <= '0;
            chk <= '0;
            cnt <= '0;
        end else if (shift) begin
            pkt <= {pkt[4*NNYB-5:0], nyb_in};
            chk <= chk ^ nyb_in;
            cnt <= cnt + 1'b1;
        end
    end

    // High while the nibble being shifted this cycle is the final data nibble.
    assign last = (cnt == LAST_IDX);

endmodule

// File: rtl/grid_link_rx.sv
// rtl/grid_link_rx.sv - grid link receiver: SOF hunt, deserialize, check, output register and cts
module grid_link_rx
    import grid_link_pkg::*;
#(
    parameter logic [3:0] SOF   = GRID_SOF,
    parameter int         NNYB  = GRID_NNYB,
    parameter int         CNT_W = 16
) (
    input  logic                clk57,
    input  logic                rst,
    input  logic [3:0]          rxd,
    output logic [4*NNYB-1:0]   dat_o,
    output logic                vld_o,
    input  logic                rdy_i,
    output logic                cts_o,
    output logic                busy_o,
    output logic [CNT_W-1:0]    err_cnt_o,
    output logic [CNT_W-1:0]    ovf_cnt_o
);

    localparam int PW = 4 * NNYB;

    grid_state_t    state;
    grid_state_t    state_nxt;
    logic [3:0]     rxd_q;
    logic           clr;
    logic           shift;
    logic           load;
    logic           drop;
    logic           err_inc;
    logic [PW-1:0]  pkt;
    logic [3:0]     chk;
    logic           last;

    always_ff @(posedge clk57) begin
        if (rst) rxd_q <= GRID_IDLE;
        else     rxd_q <= rxd;
    end

    grid_nyb_deser #(.NNYB(NNYB)) u_deser (
        .clk57  (clk57),
        .rst    (rst),
        .clr    (clr),
        .shift  (shift),
        .nyb_in (rxd_q),
        .pkt    (pkt),
        .chk    (chk),
        .last   (last)
    );

    always_ff @(posedge clk57) begin
        if (rst) state <= HUNT;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            HUNT:    if (rxd_q == SOF) state_nxt = DATA;
            DATA:    if (last)         state_nxt = CHECK;
            CHECK:   state_nxt = HUNT;
            default: state_nxt = HUNT;
        endcase
    end

    always_comb begin
        clr     = 1'b0;
        shift   = 1'b0;
        load    = 1'b0;
        drop    = 1'b0;
        err_inc = 1'b0;
        case (state)
            HUNT:  clr   = (rxd_q == SOF);
            DATA:  shift = 1'b1;
            CHECK: begin
                if (rxd_q != chk) begin
                    err_inc = 1'b1;
                end else if (pkt[PW-1 -: 8] != 8'h00) begin
                    // Null packets (leading byte zero) fall through silently.
                    if (!vld_o || rdy_i) load = 1'b1;
                    else                 drop = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk57) begin
        if (rst) begin
            dat_o <= '0;
            vld_o <= 1'b0;
            cts_o <= 1'b1;
        end else begin
            if (load) begin
                dat_o <= pkt;
                vld_o <= 1'b1;
            end else if (rdy_i) begin
                vld_o <= 1'b0;
            end
            cts_o <= !(vld_o && !rdy_i);
        end
    end

    always_ff @(posedge clk57) begin
        if (rst) begin
            err_cnt_o <= '0;
            ovf_cnt_o <= '0;
        end else begin
            if (err_inc && (err_cnt_o != '1)) err_cnt_o <= err_cnt_o + 1'b1;
            if (drop && (ovf_cnt_o != '1))    ovf_cnt_o <= ovf_cnt_o + 1'b1;
        end
    end

    assign busy_o = (state == DATA) || (state == CHECK);

endmodule

// File: tb/tb_grid_link_rx.sv
// tb/tb_grid_link_rx.sv - directed self-checking bench for grid_link_rx
module tb_grid_link_rx;
    import grid_link_pkg::*;

    logic           clk57 = 1'b0;
    logic           rst;
    logic [3:0]     rxd;
    logic [127:0]   dat_o;
    logic           vld_o;
    logic           rdy_i;
    logic           cts_o;
    logic           busy_o;
    logic [15:0]    err_cnt_o;
    logic [15:0]    ovf_cnt_o;

    int vectors     = 0;
    int miscompares = 0;

    localparam logic [127:0] PKT_A = 128'h123456789ABCDEF00000000000000000;
    localparam logic [127:0] PKT_B = 128'hFEDCBA98765432100011223344556677;
    localparam logic [127:0] PKT_N = 128'h00ABCDEF123456789ABCDEF011223344;

    grid_link_rx dut (
        .clk57     (clk57),
        .rst       (rst),
        .rxd       (rxd),
        .dat_o     (dat_o),
        .vld_o     (vld_o),
        .rdy_i     (rdy_i),
        .cts_o     (cts_o),
        .busy_o    (busy_o),
        .err_cnt_o (err_cnt_o),
        .ovf_cnt_o (ovf_cnt_o)
    );

    always #5 clk57 = ~clk57;

    task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [3:0] xor_nybs(input logic [127:0] p);
        logic [3:0] r;
        r = 4'h0;
        for (int i = 0; i < 32; i++) r = r ^ p[4*i +: 4];
        return r;
    endfunction

    task automatic step();
        @(posedge clk57);
        #1;
    endtask

    task automatic send_nyb(input logic [3:0] n);
        rxd = n;
        step();
    endtask

    task automatic send_body(input logic [127:0] p, input logic [3:0] flip, input int start);
        for (int i = start; i < 32; i++) send_nyb(p[127-4*i -: 4]);
        send_nyb(xor_nybs(p) ^ flip);
    endtask

    task automatic send_frame(input logic [127:0] p, input logic [3:0] flip);
        send_nyb(GRID_SOF);
        send_body(p, flip, 0);
    endtask

    initial begin
        rst   = 1'b1;
        rxd   = 4'h0;
        rdy_i = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("rst_vld",  vld_o,     0);
        check("rst_dat",  dat_o,     0);
        check("rst_cts",  cts_o,     1);
        check("rst_busy", busy_o,    0);
        check("rst_err",  err_cnt_o, 0);
        check("rst_ovf",  ovf_cnt_o, 0);

        // single good frame; check nibble of PKT_A is 0
        check("a_chk_const", xor_nybs(PKT_A), 4'h0);
        send_frame(PKT_A, 4'h0);
        check("a_busy_chk", busy_o, 1);
        check("a_vld_k1",   vld_o,  0);
        send_nyb(4'h0);
        check("a_vld_k2",   vld_o,  1);
        check("a_byte",     dat_o[127:120], 8'h12);
        check("a_dat",      dat_o,  PKT_A);
        check("a_busy_idle", busy_o, 0);
        send_nyb(4'h0);
        check("a_vld_fall", vld_o,  0);
        check("a_err",      err_cnt_o, 0);
        check("a_ovf",      ovf_cnt_o, 0);

        // bad check nibble, then a good frame
        send_frame(PKT_A, 4'h1);
        send_nyb(4'h0);
        check("bad_vld",  vld_o,     0);
        check("bad_err",  err_cnt_o, 1);
        check("bad_busy", busy_o,    0);
        send_frame(PKT_B, 4'h0);
        send_nyb(4'h0);
        check("b_vld", vld_o, 1);
        check("b_dat", dat_o, PKT_B);
        send_nyb(4'h0);
        check("b_vld_fall", vld_o, 0);

        // null packet
        send_frame(PKT_N, 4'h0);
        check("null_vld_k1", vld_o, 0);
        send_nyb(4'h0);
        check("null_vld_k2", vld_o, 0);
        send_nyb(4'h0);
        check("null_vld_k3", vld_o, 0);
        check("null_err",    err_cnt_o, 1);
        check("null_ovf",    ovf_cnt_o, 0);

        // backpressure, frames back-to-back
        rdy_i = 1'b0;
        send_frame(PKT_A, 4'h0);
        send_nyb(GRID_SOF);
        check("bp_vld_rise", vld_o, 1);
        check("bp_dat_a",    dat_o, PKT_A);
        check("bp_cts_rise", cts_o, 1);
        send_nyb(PKT_B[127:124]);
        check("bp_cts_low",  cts_o, 0);
        send_body(PKT_B, 4'h0, 1);
        send_nyb(4'h0);
        check("bp_ovf",      ovf_cnt_o, 1);
        check("bp_vld_hold", vld_o, 1);
        check("bp_dat_hold", dat_o, PKT_A);
        check("bp_cts_hold", cts_o, 0);
        check("bp_err",      err_cnt_o, 1);
        rdy_i = 1'b1;
        step();
        check("bp_vld_fall", vld_o, 0);
        check("bp_cts_back", cts_o, 1);

        // accept and reload in the same cycle
        rdy_i = 1'b0;
        send_frame(PKT_A, 4'h0);
        send_nyb(GRID_SOF);
        check("sim_vld_a", vld_o, 1);
        check("sim_dat_a", dat_o, PKT_A);
        send_body(PKT_B, 4'h0, 0);
        check("sim_busy_chk", busy_o, 1);
        check("sim_cts_low",  cts_o,  0);
        rdy_i = 1'b1;
        send_nyb(4'h0);
        check("sim_vld_b", vld_o, 1);
        check("sim_dat_b", dat_o, PKT_B);
        check("sim_ovf",   ovf_cnt_o, 1);
        send_nyb(4'h0);
        check("sim_vld_fall", vld_o, 0);

        // reset after 10 data nibbles; the rest of PKT_A contains no SOF
        send_nyb(GRID_SOF);
        for (int i = 0; i < 10; i++) send_nyb(PKT_A[127-4*i -: 4]);
        check("mid_busy_pre", busy_o, 1);
        rst = 1'b1;
        send_nyb(4'h0);
        rst = 1'b0;
        check("mid_busy", busy_o, 0);
        check("mid_vld",  vld_o,  0);
        check("mid_cts",  cts_o,  1);
        check("mid_err",  err_cnt_o, 0);
        check("mid_ovf",  ovf_cnt_o, 0);
        send_body(PKT_A, 4'h0, 10);
        check("mid_tail_busy", busy_o, 0);
        send_nyb(4'h0);
        check("mid_tail_vld", vld_o, 0);
        check("mid_tail_err", err_cnt_o, 0);
        send_frame(PKT_B, 4'h0);
        send_nyb(4'h0);
        check("mid_next_vld", vld_o, 1);
        check("mid_next_dat", dat_o, PKT_B);
        check("mid_next_err", err_cnt_o, 0);
        check("mid_next_ovf", ovf_cnt_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
